// File: rtl/modsel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : modsel_pkg
//  Purpose  : Shared types and codes for the modulator select controller:
//             sequencer states, CSR word addresses, waveform and modulation
//             select codes, and the auto-mode modulation step helper.
//  Revision : 1.0 - initial release
// ============================================================================
package modsel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      APPLY = 2'd2
   } state_t;

   // CSR word addresses
   localparam logic [1:0] ADDR_SEL  = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;
   localparam logic [1:0] ADDR_STAT = 2'd2;
   localparam logic [1:0] ADDR_CNT  = 2'd3;

   // Modulation select codes
   localparam logic [3:0] MOD_NONE = 4'd0;
   localparam logic [3:0] MOD_BPSK = 4'd1;
   localparam logic [3:0] MOD_ASK  = 4'd2;

   // Carrier waveform select codes
   localparam logic [7:0] SIG_SIN    = 8'd0;
   localparam logic [7:0] SIG_COS    = 8'd1;
   localparam logic [7:0] SIG_SQUARE = 8'd2;
   localparam logic [7:0] SIG_SAW    = 8'd3;

   // Next modulation in the auto-mode rotation, wrapping back to MOD_NONE.
   function automatic logic [3:0] next_mod(input logic [3:0] cur, input int unsigned num);
      if ({28'd0, cur} + 32'd1 >= num)
         return MOD_NONE;
      else
         return cur + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/modsel_dwell_counter.sv
`default_nettype none
// ============================================================================
//  Module   : modsel_dwell_counter
//  Purpose  : Counts waveform periods while auto mode is enabled and flags
//             the wrap on which the programmed dwell expires. A dwell of 0
//             behaves as a dwell of 1.
//  Revision : 1.0 - initial release
// ============================================================================
module modsel_dwell_counter #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               wrap,
   input  logic               clear,
   input  logic [DWELL_W-1:0] dwell,
   output logic               terminal
);

   localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   logic [DWELL_W-1:0] r_count;
   logic [DWELL_W-1:0] w_dwell_eff;

   // Dwell expiry: a wrap arriving while the count sits at dwell-1.
   always_comb begin
      w_dwell_eff = (dwell == '0) ? ONE : dwell;
      terminal    = enable & wrap & ~clear & (r_count == (w_dwell_eff - ONE));
   end

   // Period counter: held at zero when disabled or cleared, restarts on expiry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_count <= '0;
      else if (clear || !enable)
         r_count <= '0;
      else if (terminal)
         r_count <= '0;
      else if (wrap)
         r_count <= r_count + ONE;
   end

endmodule
`default_nettype wire

// File: rtl/modulator_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : modulator_select_ctrl
//  Purpose  : Avalon-MM controlled sequencer for the waveform / modulation
//             selector. Requests are held pending and applied only on a
//             waveform period boundary (or an explicit force), so the DAC
//             path never switches mid-cycle. Optional auto mode rotates the
//             modulation every DWELL waveform periods.
//  Revision : 1.0 - initial release
// ============================================================================
module modulator_select_ctrl
   import modsel_pkg::*;
#(
   parameter int NUM_SIG = 4,
   parameter int NUM_MOD = 3,
   parameter int DWELL_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        period_wrap,
   output logic [7:0]  signal_selector,
   output logic [3:0]  modulation_selector,
   output logic        update_pending,
   output logic        update_done
);

   localparam logic [31:0] NUM_SIG_U = 32'(NUM_SIG);
   localparam logic [31:0] NUM_MOD_U = 32'(NUM_MOD);
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rearm;
   logic                w_rearm_nxt;
   logic                w_load_pending;
   logic                w_load_auto;

   logic [7:0]          r_pend_sig;
   logic [3:0]          r_pend_mod;
   logic [7:0]          r_act_sig;
   logic [3:0]          r_act_mod;
   logic                r_auto_en;
   logic [DWELL_W-1:0]  r_dwell;
   logic                r_err;
   logic [15:0]         r_upd_cnt;
   logic [31:0]         r_readdata;

   logic                w_wr_sel;
   logic                w_wr_ctrl;
   logic                w_wr_stat;
   logic                w_wr_cnt;
   logic                w_sel_ok;
   logic                w_sel_valid;
   logic                w_sel_bad;
   logic                w_force;
   logic                w_auto_term;
   logic [31:0]         w_rd_mux;
   logic                unused_wdata_bits;

   // CSR write decode and SEL request validation.
   always_comb begin
      w_wr_sel    = avs_write && (avs_address == ADDR_SEL);
      w_wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
      w_wr_stat   = avs_write && (avs_address == ADDR_STAT);
      w_wr_cnt    = avs_write && (avs_address == ADDR_CNT);
      w_sel_ok    = ({24'd0, avs_writedata[7:0]}  < NUM_SIG_U) &&
                    ({28'd0, avs_writedata[11:8]} < NUM_MOD_U);
      w_sel_valid = w_wr_sel & w_sel_ok;
      w_sel_bad   = w_wr_sel & ~w_sel_ok;
      w_force     = w_wr_ctrl & avs_writedata[1];
   end

   assign unused_wdata_bits = ^avs_writedata[15:12];

   // Auto-mode period counter; any CTRL write restarts the dwell.
   modsel_dwell_counter #(
      .DWELL_W (DWELL_W)
   ) u_dwell (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (r_auto_en),
      .wrap     (period_wrap),
      .clear    (w_wr_ctrl),
      .dwell    (r_dwell),
      .terminal (w_auto_term)
   );

   // Sequencer state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_rearm <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rearm <= w_rearm_nxt;
      end
   end

   // Next-state and handshake outputs. A manual request that is already armed
   // owns the wrap, so an auto step landing on it (or on the APPLY cycle) is
   // dropped; the dwell counter restarts either way. A SEL write accepted on
   // the same edge that launches an apply becomes the next armed request.
   always_comb begin
      w_state_nxt    = r_state;
      w_rearm_nxt    = 1'b0;
      w_load_pending = 1'b0;
      w_load_auto    = 1'b0;
      update_pending = 1'b0;
      update_done    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_auto_term) begin
               w_state_nxt = APPLY;
               w_load_auto = 1'b1;
               w_rearm_nxt = w_sel_valid;
            end else if (w_sel_valid) begin
               w_state_nxt = ARMED;
            end
         end
         ARMED: begin
            update_pending = 1'b1;
            if (period_wrap || w_force) begin
               w_state_nxt    = APPLY;
               w_load_pending = 1'b1;
               w_rearm_nxt    = w_sel_valid;
            end
         end
         APPLY: begin
            update_done = 1'b1;
            w_state_nxt = (r_rearm || w_sel_valid) ? ARMED : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Pending request, active selects, control and status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_sig <= '0;
         r_pend_mod <= '0;
         r_act_sig  <= '0;
         r_act_mod  <= '0;
         r_auto_en  <= 1'b0;
         r_dwell    <= '0;
         r_err      <= 1'b0;
         r_upd_cnt  <= '0;
      end else begin
         if (w_sel_valid) begin
            r_pend_sig <= avs_writedata[7:0];
            r_pend_mod <= avs_writedata[11:8];
         end
         if (w_load_pending) begin
            r_act_sig <= r_pend_sig;
            r_act_mod <= r_pend_mod;
         end else if (w_load_auto) begin
            r_act_mod <= next_mod(r_act_mod, NUM_MOD);
         end
         if (w_wr_ctrl) begin
            r_auto_en <= avs_writedata[0];
            r_dwell   <= avs_writedata[16 +: DWELL_W];
         end
         if (w_wr_stat)
            r_err <= 1'b0;
         else if (w_sel_bad)
            r_err <= 1'b1;
         if (w_wr_cnt)
            r_upd_cnt <= '0;
         else if ((w_load_pending || w_load_auto) && (r_upd_cnt != CNT_MAX))
            r_upd_cnt <= r_upd_cnt + 16'd1;
      end
   end

   // CSR read multiplexer; force is a strobe and always reads back as 0.
   always_comb begin
      w_rd_mux = '0;
      case (avs_address)
         ADDR_SEL:  w_rd_mux = {20'd0, r_pend_mod, r_pend_sig};
         ADDR_CTRL: begin
            w_rd_mux[16 +: DWELL_W] = r_dwell;
            w_rd_mux[0]             = r_auto_en;
         end
         ADDR_STAT: w_rd_mux = {12'd0, r_act_mod, r_act_sig, 6'd0, r_err, (r_state == ARMED)};
         ADDR_CNT:  w_rd_mux = {16'd0, r_upd_cnt};
         default:   w_rd_mux = '0;
      endcase
   end

   // Read data register: one cycle latency, holds between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_readdata <= '0;
      else if (avs_read)
         r_readdata <= w_rd_mux;
   end

   assign avs_readdata        = r_readdata;
   assign signal_selector     = r_act_sig;
   assign modulation_selector = r_act_mod;

endmodule
`default_nettype wire
